// File: rtl/uart_pkt_pkg.sv
// Shared frame constants and state encoding for the UART packet transmitter and receive-side parser.
// The optional resend/retry feature in uart_packet_tx is enabled by defining UART_PKT_RESEND_EN.
package uart_pkt_pkg;

    localparam logic [7:0] START_BYTE = 8'hFF;
    localparam logic [7:0] TRAIN_BYTE = 8'hF0;
    localparam logic [7:0] TEST_BYTE  = 8'h0F;
    localparam logic [7:0] STOP_BYTE  = 8'hFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        MODE     = 3'd2,
        DATA     = 3'd3,
        CHECK    = 3'd4,
        STOP     = 3'd5,
        WAIT_ACK = 3'd6
    } pkt_state_t;

    function automatic logic [7:0] mode_byte(input logic train);
        return train ? TRAIN_BYTE : TEST_BYTE;
    endfunction

endpackage

// File: rtl/ones_comp_add.sv
// 8-bit ones'-complement adder: the carry out of the MSB wraps back into the LSB.
module ones_comp_add (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum
);

    logic [8:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};
    assign sum = raw[7:0] + {7'd0, raw[8]};

endmodule

// File: rtl/uart_packet_tx.sv
// Frames an image as START, MODE, data bytes (MSB first), checksum, STOP for a byte serializer.
// Define UART_PKT_RESEND_EN to wait for a resend request after STOP and retransmit up to MAX_RETRY times.
module uart_packet_tx
    import uart_pkt_pkg::*;
#(
    parameter int IMG_SZ    = 784 << 3,
    parameter int ACK_WAIT  = 1024,
    parameter int MAX_RETRY = 3
) (
    input  logic              uart_sampling_clk,
    input  logic              rst,
    input  logic              send,
    input  logic              train,
    input  logic [IMG_SZ-1:0] image,
    input  logic              resend,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_byte,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int NBYTES = IMG_SZ / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    pkt_state_t        state, state_next;
    logic [IMG_SZ-1:0] frame;
    logic              train_q;
    logic [7:0]        cksum;
    logic [7:0]        cksum_sum;
    logic [CW-1:0]     byte_cnt;
    logic              load;
    logic              finish;

`ifdef UART_PKT_RESEND_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TW = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;

    logic [RW-1:0] retry_cnt;
    logic [TW-1:0] ack_timer;
    logic          fail;
    logic          restart;
`else
    localparam int unused_cfg = ACK_WAIT + MAX_RETRY;
    logic unused_resend;

    assign unused_resend = resend;
    assign err           = 1'b0;
`endif

    // The frame register's top byte is always the data byte on the wire.
    ones_comp_add u_cksum_add (
        .a   (cksum),
        .b   (frame[IMG_SZ-1 -: 8]),
        .sum (cksum_sum)
    );

    assign tx_valid = (state != IDLE) && (state != WAIT_ACK);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        tx_byte    = 8'h00;
`ifdef UART_PKT_RESEND_EN
        fail       = 1'b0;
        restart    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (send) begin
                    state_next = START;
                    load       = 1'b1;
                end
            end
            START: begin
                tx_byte = START_BYTE;
                if (tx_ready) state_next = MODE;
            end
            MODE: begin
                tx_byte = mode_byte(train_q);
                if (tx_ready) state_next = DATA;
            end
            DATA: begin
                tx_byte = frame[IMG_SZ-1 -: 8];
                if (tx_ready && (byte_cnt == CW'(NBYTES - 1))) state_next = CHECK;
            end
            CHECK: begin
                tx_byte = cksum;
                if (tx_ready) state_next = STOP;
            end
            STOP: begin
                tx_byte = STOP_BYTE;
                if (tx_ready) begin
`ifdef UART_PKT_RESEND_EN
                    state_next = WAIT_ACK;
`else
                    state_next = IDLE;
                    finish     = 1'b1;
`endif
                end
            end
            WAIT_ACK: begin
`ifdef UART_PKT_RESEND_EN
                // A resend on the last window cycle still wins over the timeout.
                if (resend) begin
                    if (retry_cnt == RW'(MAX_RETRY)) begin
                        state_next = IDLE;
                        finish     = 1'b1;
                        fail       = 1'b1;
                    end else begin
                        state_next = START;
                        restart    = 1'b1;
                    end
                end else if (ack_timer == TW'(ACK_WAIT - 1)) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Rotating left by a byte per data transfer leaves the original image in place after a full frame.
    always_ff @(posedge uart_sampling_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            frame    <= '0;
            train_q  <= 1'b0;
            cksum    <= 8'h00;
            byte_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_next;
            done  <= finish;
            if (load) begin
                frame    <= image;
                train_q  <= train;
                cksum    <= 8'h00;
                byte_cnt <= '0;
                busy     <= 1'b1;
            end else if ((state == DATA) && tx_ready) begin
                frame    <= (frame << 8) | (frame >> (IMG_SZ - 8));
                cksum    <= cksum_sum;
                byte_cnt <= byte_cnt + 1'b1;
            end
`ifdef UART_PKT_RESEND_EN
            else if (restart) begin
                cksum    <= 8'h00;
                byte_cnt <= '0;
            end
`endif
            if (finish) busy <= 1'b0;
        end
    end

`ifdef UART_PKT_RESEND_EN
    always_ff @(posedge uart_sampling_clk or posedge rst) begin
        if (rst) begin
            retry_cnt <= '0;
            ack_timer <= '0;
            err       <= 1'b0;
        end else begin
            err <= fail;
            if (load) begin
                retry_cnt <= '0;
            end else if (restart) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
            ack_timer <= (state == WAIT_ACK) ? ack_timer + 1'b1 : '0;
        end
    end
`endif

endmodule
